// File: rtl/inst_fetcher.sv
// inst_fetcher: instruction fetch unit in front of the Decoder.
//   Holds the PC, looks it up in a direct-mapped one-word-per-line instruction
//   cache and reads the word from the memory controller on a miss. One
//   instruction at a time is offered on valid/inst_addr/inst.
// Ports:
//   clk_in, rst_in (async, active-high), rdy_in (global freeze when low)
//   valid, inst_addr, inst        : registered instruction toward the Decoder
//   if_stall                      : Decoder back-pressure
//   if_clear, if_set_addr         : Decoder redirect after a control-flow instruction
//   rob_clear, rob_set_addr       : ROB mispredict flush (highest priority)
//   mem_req_valid, mem_req_addr   : word read request, held until response
//   mem_resp_valid, mem_resp_data : single-cycle read response
module inst_fetcher #(
  parameter logic [31:0] RESET_ADDR   = 32'h0,
  parameter int unsigned ICACHE_LINES = 64
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  output logic        valid,
  output logic [31:0] inst_addr,
  output logic [31:0] inst,
  input  logic        if_stall,
  input  logic        if_clear,
  input  logic [31:0] if_set_addr,
  input  logic        rob_clear,
  input  logic [31:0] rob_set_addr,
  output logic        mem_req_valid,
  output logic [31:0] mem_req_addr,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_data
);

  localparam int unsigned IDX_W = $clog2(ICACHE_LINES);
  localparam int unsigned TAG_W = 32 - IDX_W - 2;

  localparam logic [6:0] OPC_JAL  = 7'b1101111;
  localparam logic [6:0] OPC_JALR = 7'b1100111;
  localparam logic [6:0] OPC_BR   = 7'b1100011;

  typedef enum logic [1:0] {StFetch, StMem, StPresent, StRedirect} state_e;

  state_e      r_state, w_state_nxt;
  logic [31:0] r_pc, w_pc_nxt;
  logic        r_valid, w_valid_nxt;
  logic [31:0] r_inst, w_inst_nxt;
  logic [31:0] r_inst_addr, w_inst_addr_nxt;
  logic        r_req_valid, w_req_valid_nxt;
  logic [31:0] r_req_addr, w_req_addr_nxt;
  logic        r_discard, w_discard_nxt;

  logic [TAG_W-1:0]        r_tag  [ICACHE_LINES];
  logic [31:0]             r_data [ICACHE_LINES];
  logic [ICACHE_LINES-1:0] r_line_vld;

  logic [IDX_W-1:0] w_idx;
  logic [IDX_W-1:0] w_fill_idx;
  logic             w_hit;
  logic             w_fill;
  logic             w_is_cf;

  assign w_idx      = r_pc[IDX_W+1:2];
  assign w_fill_idx = r_req_addr[IDX_W+1:2];
  assign w_hit      = r_line_vld[w_idx] && (r_tag[w_idx] == r_pc[31:IDX_W+2]);
  // The controller never pulses a response while rdy_in is low; gating keeps the freeze exact.
  assign w_fill     = rdy_in && (r_state == StMem) && mem_resp_valid;
  assign w_is_cf    = (r_inst[6:0] == OPC_JAL) || (r_inst[6:0] == OPC_JALR) ||
                      (r_inst[6:0] == OPC_BR);

  always_comb begin
    w_state_nxt     = r_state;
    w_pc_nxt        = r_pc;
    w_valid_nxt     = r_valid;
    w_inst_nxt      = r_inst;
    w_inst_addr_nxt = r_inst_addr;
    w_req_valid_nxt = r_req_valid;
    w_req_addr_nxt  = r_req_addr;
    w_discard_nxt   = r_discard;
    if (rdy_in) begin
      if (rob_clear) begin
        w_valid_nxt = 1'b0;
        w_pc_nxt    = rob_set_addr;
        if ((r_state == StMem) && !mem_resp_valid) begin
          // Outstanding read cannot be withdrawn: wait for it, then drop the word.
          w_discard_nxt = 1'b1;
        end else begin
          // A response landing in the flush cycle still fills the cache (w_fill).
          w_state_nxt     = StFetch;
          w_discard_nxt   = 1'b0;
          w_req_valid_nxt = (r_state == StMem) ? 1'b0 : r_req_valid;
        end
      end else begin
        unique case (r_state)
          StFetch: begin
            if (w_hit) begin
              w_inst_nxt      = r_data[w_idx];
              w_inst_addr_nxt = r_pc;
              w_valid_nxt     = 1'b1;
              w_state_nxt     = StPresent;
            end else begin
              w_req_valid_nxt = 1'b1;
              w_req_addr_nxt  = r_pc;
              w_state_nxt     = StMem;
            end
          end
          StMem: begin
            if (mem_resp_valid) begin
              w_req_valid_nxt = 1'b0;
              if (r_discard) begin
                w_discard_nxt = 1'b0;
                w_state_nxt   = StFetch;
              end else begin
                w_inst_nxt      = mem_resp_data;
                w_inst_addr_nxt = r_req_addr;
                w_valid_nxt     = 1'b1;
                w_state_nxt     = StPresent;
              end
            end
          end
          StPresent: begin
            if (!if_stall) begin
              w_valid_nxt = 1'b0;
              if (w_is_cf) begin
                // Hold the PC; the Decoder supplies the target via if_clear.
                w_state_nxt = StRedirect;
              end else begin
                w_pc_nxt    = r_pc + 32'd4;
                w_state_nxt = StFetch;
              end
            end
          end
          StRedirect: begin
            if (if_clear) begin
              w_pc_nxt    = if_set_addr;
              w_state_nxt = StFetch;
            end
          end
          default: w_state_nxt = StFetch;
        endcase
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_state     <= StFetch;
      r_pc        <= RESET_ADDR;
      r_valid     <= 1'b0;
      r_inst      <= 32'h0;
      r_inst_addr <= 32'h0;
      r_req_valid <= 1'b0;
      r_req_addr  <= 32'h0;
      r_discard   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_pc        <= w_pc_nxt;
      r_valid     <= w_valid_nxt;
      r_inst      <= w_inst_nxt;
      r_inst_addr <= w_inst_addr_nxt;
      r_req_valid <= w_req_valid_nxt;
      r_req_addr  <= w_req_addr_nxt;
      r_discard   <= w_discard_nxt;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_line_vld <= '0;
    end else if (w_fill) begin
      r_line_vld[w_fill_idx] <= 1'b1;
    end
  end

  // Tag/data need no reset: they are qualified by r_line_vld.
  always_ff @(posedge clk_in) begin
    if (w_fill) begin
      r_tag[w_fill_idx]  <= r_req_addr[31:IDX_W+2];
      r_data[w_fill_idx] <= mem_resp_data;
    end
  end

  assign valid         = r_valid;
  assign inst_addr     = r_inst_addr;
  assign inst          = r_inst;
  assign mem_req_valid = r_req_valid;
  assign mem_req_addr  = r_req_addr;

endmodule
